// File: rtl/tune_ctrl.sv
// Channel tuning controller: phase-increment table, retune/settle/measure/play sequencing, level averaging.
// Optional auto-scan is built only when TUNE_SCAN_EN is defined.
module tune_ctrl #(
   parameter int unsigned SETTLE_TICKS = 32,
   parameter int unsigned MEAS_LOG2    = 8
) (
   input  logic        clk,
   input  logic        RSTb,
   input  logic        next_req,
   input  logic        prev_req,
   input  logic        sel_req,
   input  logic [2:0]  sel_chan,
   input  logic        scan_req,
   input  logic [15:0] scan_thresh,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_addr,
   input  logic [39:0] cfg_data,
   input  logic [15:0] demod_in,
   input  logic        demod_tick,
   output logic [39:0] phase_inc,
   output logic [2:0]  chan,
   output logic        busy,
   output logic        mute,
   output logic [15:0] audio_out,
   output logic [15:0] level
);

   localparam int unsigned INC_W  = 40;
   localparam int unsigned ACC_W  = 24;
   localparam int unsigned SET_W  = 8;
   localparam int unsigned MCNT_W = 8;
   localparam int unsigned MEAS_N = 32'(1) << MEAS_LOG2;
   localparam logic [INC_W-1:0] RST_INC = 40'h7FCB923A2;

   typedef enum logic [1:0] {S_RETUNE, S_SETTLE, S_MEASURE, S_PLAY} state_t;

   state_t             r_state;
   logic [INC_W-1:0]   r_table [8];
   logic [INC_W-1:0]   r_phase_inc;
   logic [2:0]         r_chan;
   logic               r_busy;
   logic               r_mute;
   logic [15:0]        r_audio;
   logic [15:0]        r_level;
   logic [SET_W-1:0]   r_scnt;
   logic [MCNT_W-1:0]  r_mcnt;
   logic [ACC_W-1:0]   r_acc;

   logic [ACC_W-1:0]   w_acc_sum;
   logic [15:0]        w_level_new;
   logic               w_settle_last;
   logic               w_meas_last;
   logic               w_cfg_hit;
   logic [2:0]         w_chan_inc;
   logic [2:0]         w_chan_dec;
   logic               w_play_retune;
   logic [2:0]         w_play_chan;

   assign w_acc_sum     = r_acc + ACC_W'(demod_in);
   assign w_level_new   = 16'(w_acc_sum >> MEAS_LOG2);
   assign w_settle_last = (r_scnt == SET_W'(SETTLE_TICKS - 1));
   assign w_meas_last   = (r_mcnt == MCNT_W'(MEAS_N - 1));
   assign w_cfg_hit     = cfg_we && (cfg_addr == r_chan);
   assign w_chan_inc    = r_chan + 3'd1;
   assign w_chan_dec    = r_chan - 3'd1;

`ifdef TUNE_SCAN_EN
   logic       r_scan_active;
   logic [3:0] r_lap;
   logic [3:0] w_lap_inc;
   logic       w_scan_pass;
   logic       w_scan_start;

   assign w_lap_inc    = r_lap + 4'd1;
   assign w_scan_pass  = (w_level_new >= scan_thresh);
   assign w_scan_start = scan_req && !sel_req && !next_req && !prev_req;
`else
   logic w_unused_scan;
   assign w_unused_scan = ^{scan_req, scan_thresh};
`endif

   // Request arbitration in PLAY: sel > next > prev (> scan), then table write to the live channel.
   always_comb begin
      w_play_chan   = r_chan;
      w_play_retune = 1'b0;
      if (sel_req) begin
         w_play_chan   = sel_chan;
         w_play_retune = 1'b1;
      end else if (next_req) begin
         w_play_chan   = w_chan_inc;
         w_play_retune = 1'b1;
      end else if (prev_req) begin
         w_play_chan   = w_chan_dec;
         w_play_retune = 1'b1;
`ifdef TUNE_SCAN_EN
      end else if (scan_req) begin
         w_play_chan   = w_chan_inc;
         w_play_retune = 1'b1;
`endif
      end else if (w_cfg_hit) begin
         w_play_retune = 1'b1;
      end
   end

   // Phase-increment table, writable in every state.
   always_ff @(posedge clk or negedge RSTb) begin
      if (!RSTb) begin
         r_table[0] <= RST_INC;
         for (int i = 1; i < 8; i++) r_table[i] <= '0;
      end else if (cfg_we) begin
         r_table[cfg_addr] <= cfg_data;
      end
   end

   always_ff @(posedge clk or negedge RSTb) begin
      if (!RSTb) begin
         r_state     <= S_RETUNE;
         r_chan      <= 3'd0;
         r_busy      <= 1'b1;
         r_mute      <= 1'b1;
         r_audio     <= '0;
         r_level     <= '0;
         r_scnt      <= '0;
         r_mcnt      <= '0;
         r_acc       <= '0;
         r_phase_inc <= RST_INC;
`ifdef TUNE_SCAN_EN
         r_scan_active <= 1'b0;
         r_lap         <= '0;
`endif
      end else begin
         case (r_state)
            S_RETUNE: begin
               r_phase_inc <= w_cfg_hit ? cfg_data : r_table[r_chan];
               r_scnt      <= '0;
               r_mcnt      <= '0;
               r_acc       <= '0;
               r_state     <= S_SETTLE;
            end
            S_SETTLE: begin
               if (demod_tick) begin
                  if (w_settle_last) r_state <= S_MEASURE;
                  else               r_scnt  <= r_scnt + SET_W'(1);
               end
            end
            S_MEASURE: begin
               if (demod_tick) begin
                  r_acc  <= w_acc_sum;
                  r_mcnt <= r_mcnt + MCNT_W'(1);
                  if (w_meas_last) begin
                     r_level <= w_level_new;
                     r_state <= S_PLAY;
                     r_mute  <= 1'b0;
                     r_busy  <= 1'b0;
`ifdef TUNE_SCAN_EN
                     // A failed scan step hops to the next channel unless all 8 have been tried.
                     if (r_scan_active) begin
                        if (!w_scan_pass && (w_lap_inc != 4'd8)) begin
                           r_lap   <= w_lap_inc;
                           r_chan  <= w_chan_inc;
                           r_state <= S_RETUNE;
                           r_mute  <= 1'b1;
                           r_busy  <= 1'b1;
                        end else begin
                           r_scan_active <= 1'b0;
                        end
                     end
`endif
                  end
               end
            end
            S_PLAY: begin
               if (w_play_retune) begin
                  r_chan  <= w_play_chan;
                  r_state <= S_RETUNE;
                  r_mute  <= 1'b1;
                  r_busy  <= 1'b1;
                  r_audio <= '0;
`ifdef TUNE_SCAN_EN
                  if (w_scan_start) begin
                     r_scan_active <= 1'b1;
                     r_lap         <= '0;
                  end
`endif
               end else if (demod_tick) begin
                  r_audio <= demod_in;
               end
            end
            default: r_state <= S_RETUNE;
         endcase
      end
   end

   assign phase_inc = r_phase_inc;
   assign chan      = r_chan;
   assign busy      = r_busy;
   assign mute      = r_mute;
   assign audio_out = r_audio;
   assign level     = r_level;

endmodule

// File: tb/tb_tune_ctrl.sv
// Directed bench for tune_ctrl: reset, retune sequencing, request priority/drop, write-through, mid-run reset.
module tb_tune_ctrl;

   logic        clk = 1'b0;
   logic        RSTb;
   logic        next_req, prev_req, sel_req, scan_req, cfg_we, demod_tick;
   logic [2:0]  sel_chan, cfg_addr;
   logic [15:0] scan_thresh, demod_in;
   logic [39:0] cfg_data;
   logic [39:0] phase_inc;
   logic [2:0]  chan;
   logic        busy, mute;
   logic [15:0] audio_out, level;

   localparam logic [39:0] RST_INC = 40'h7FCB923A2;
   localparam logic [39:0] T7 = 40'h0A0A0A0A0A;
   localparam logic [39:0] T5 = 40'h5555555555;
   localparam logic [39:0] T2 = 40'h2222222222;

   int          n_checks = 0;
   int          n_errors = 0;
   logic        tick_en = 1'b0;
   logic        scan_mode = 1'b0;
   logic        count_en = 1'b0;
   int          mute_ticks = 0;
   logic [15:0] base_in = 16'd1000;
   logic [15:0] lvl_tab [8];

   tune_ctrl dut (
      .clk(clk), .RSTb(RSTb),
      .next_req(next_req), .prev_req(prev_req),
      .sel_req(sel_req), .sel_chan(sel_chan),
      .scan_req(scan_req), .scan_thresh(scan_thresh),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .demod_in(demod_in), .demod_tick(demod_tick),
      .phase_inc(phase_inc), .chan(chan), .busy(busy), .mute(mute),
      .audio_out(audio_out), .level(level)
   );

   initial forever #5 clk = ~clk;

   // Demodulator model: one tick every 4 cycles; sample value per channel in scan mode.
   initial begin
      int ph;
      ph = 0;
      demod_tick = 1'b0;
      demod_in   = 16'd0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_en) begin
            demod_tick = (ph == 3);
            ph = (ph + 1) % 4;
         end else begin
            demod_tick = 1'b0;
         end
         demod_in = scan_mode ? lvl_tab[chan] : base_in;
      end
   end

   initial forever begin
      @(negedge clk);
      if (count_en && demod_tick && mute) mute_ticks++;
   end

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_play(input string tag);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 15000) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 40'(busy), 40'd0);
   endtask

   task automatic do_sel(input logic [2:0] c);
      @(posedge clk); #1;
      sel_chan = c; sel_req = 1'b1;
      @(posedge clk); #1;
      sel_req = 1'b0;
   endtask

   task automatic do_cfg(input logic [2:0] a, input logic [39:0] d);
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   initial begin
      RSTb = 1'b0;
      next_req = 0; prev_req = 0; sel_req = 0; scan_req = 0; cfg_we = 0;
      sel_chan = 0; cfg_addr = 0; cfg_data = 0; scan_thresh = 16'd0;
      for (int i = 0; i < 8; i++) lvl_tab[i] = 16'd100;
      cyc(3);
      chk("rst_chan", 40'(chan), 40'd0);
      chk("rst_mute", 40'(mute), 40'd1);
      chk("rst_busy", 40'(busy), 40'd1);
      chk("rst_audio", 40'(audio_out), 40'd0);
      chk("rst_level", 40'(level), 40'd0);
      chk("rst_inc", phase_inc, RST_INC);

      // Reset release: full settle + measure of channel 0.
      @(posedge clk); #1;
      RSTb = 1'b1; count_en = 1'b1; mute_ticks = 0;
      cyc(2);
      tick_en = 1'b1;
      wait_play("play0_timeout");
      count_en = 1'b0;
      chk("mute_ticks", 40'(mute_ticks), 40'd288);
      chk("play0_level", 40'(level), 40'd1000);
      chk("play0_mute", 40'(mute), 40'd0);
      chk("play0_inc", phase_inc, RST_INC);

      base_in = 16'd1234;
      cyc(12);
      chk("audio_play", 40'(audio_out), 40'd1234);

      do_cfg(3'd7, T7);
      do_cfg(3'd5, T5);
      do_cfg(3'd2, T2);
      chk("cfg_noretune", 40'(busy), 40'd0);

      do_sel(3'd7);
      chk("sel7_chan", 40'(chan), 40'd7);
      chk("sel7_busy", 40'(busy), 40'd1);
      chk("sel7_audio", 40'(audio_out), 40'd0);
      cyc(1);
      chk("sel7_inc", phase_inc, T7);
      wait_play("sel7_timeout");

      @(posedge clk); #1; next_req = 1'b1;
      @(posedge clk); #1; next_req = 1'b0;
      chk("wrap_next_chan", 40'(chan), 40'd0);
      chk("wrap_next_busy", 40'(busy), 40'd1);
      cyc(1);
      chk("wrap_next_inc", phase_inc, RST_INC);
      wait_play("next_timeout");

      @(posedge clk); #1; prev_req = 1'b1;
      @(posedge clk); #1; prev_req = 1'b0;
      chk("wrap_prev_chan", 40'(chan), 40'd7);
      wait_play("prev_timeout");

      do_sel(3'd2);
      wait_play("sel2_timeout");
      @(posedge clk); #1; sel_chan = 3'd5; sel_req = 1'b1; next_req = 1'b1;
      @(posedge clk); #1; sel_req = 1'b0; next_req = 1'b0;
      chk("prio_chan", 40'(chan), 40'd5);
      cyc(100);
      @(posedge clk); #1; next_req = 1'b1;
      @(posedge clk); #1; next_req = 1'b0;
      chk("drop_chan", 40'(chan), 40'd5);
      chk("drop_busy", 40'(busy), 40'd1);
      chk("sel5_inc", phase_inc, T5);
      wait_play("sel5_timeout");
      chk("sel5_chan", 40'(chan), 40'd5);

      // Write-through of the live channel in the RETUNE cycle.
      base_in = 16'd3000;
      do_sel(3'd3);
      cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 40'h123456789A;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      chk("wthru_inc", phase_inc, 40'h123456789A);
      wait_play("wthru_timeout");
      chk("wthru_level", 40'(level), 40'd3000);

      do_cfg(3'd3, 40'hABCDEF0123);
      chk("cfgretune_busy", 40'(busy), 40'd1);
      chk("cfgretune_chan", 40'(chan), 40'd3);
      cyc(1);
      chk("cfgretune_inc", phase_inc, 40'hABCDEF0123);
      wait_play("cfgretune_timeout");

      // Reset during MEASURE of channel 4.
      do_sel(3'd4);
      cyc(600);
      chk("meas_chan", 40'(chan), 40'd4);
      chk("meas_mute", 40'(mute), 40'd1);
      RSTb = 1'b0;
      #1;
      chk("midrst_chan", 40'(chan), 40'd0);
      chk("midrst_mute", 40'(mute), 40'd1);
      chk("midrst_level", 40'(level), 40'd0);
      chk("midrst_inc", phase_inc, RST_INC);
      cyc(2);
      RSTb = 1'b1;
      wait_play("midrst_timeout");
      chk("midrst_play_chan", 40'(chan), 40'd0);
      chk("midrst_play_level", 40'(level), 40'd3000);

`ifdef TUNE_SCAN_EN
      scan_mode = 1'b1;
      scan_thresh = 16'd500;
      lvl_tab[2] = 16'd600;
      do_sel(3'd0);
      wait_play("scan_pre_timeout");
      @(posedge clk); #1; scan_req = 1'b1;
      @(posedge clk); #1; scan_req = 1'b0;
      chk("scan1_start_chan", 40'(chan), 40'd1);
      wait_play("scan1_timeout");
      chk("scan1_chan", 40'(chan), 40'd2);
      chk("scan1_mute", 40'(mute), 40'd0);
      chk("scan1_level", 40'(level), 40'd600);

      lvl_tab[2] = 16'd100;
      do_sel(3'd0);
      wait_play("scan2_pre_timeout");
      @(posedge clk); #1; scan_req = 1'b1;
      @(posedge clk); #1; scan_req = 1'b0;
      wait_play("scan2_timeout");
      chk("scan2_chan", 40'(chan), 40'd0);
      chk("scan2_level", 40'(level), 40'd100);
      chk("scan2_mute", 40'(mute), 40'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tune_ctrl.md
TUNE_CTRL -- requirements
Module: tune_ctrl

Interface
REQ-001 Parameter: SETTLE_TICKS, default 32, demod_tick count discarded after each retune while the CIC/demod pipeline flushes (range 1..255).
REQ-002 Parameter: MEAS_LOG2, default 8, log2 of demod_tick samples averaged per level measurement (range 1..8).
REQ-003 clk  in  1  system clock; all logic on posedge.
REQ-004 RSTb  in  1  asynchronous active-low reset.
REQ-005 next_req / prev_req  in  1 each  single-cycle pulses: step channel up / down.
REQ-006 sel_req  in  1  pulse: jump to channel sel_chan; sel_chan  in  3  target channel.
REQ-007 scan_req  in  1  pulse: start auto-scan; scan_thresh  in  16  minimum acceptable level.
REQ-008 cfg_we  in  1, cfg_addr  in  3, cfg_data  in  40: write one phase-increment table entry.
REQ-009 demod_in  in  16  unsigned AM magnitude; demod_tick  in  1  marks a valid demod_in.
REQ-010 phase_inc  out  40  NCO phase increment for the current channel.
REQ-011 chan  out  3  current channel; busy  out  1  high in any state other than PLAY.
REQ-012 mute  out  1; audio_out  out  16  registered demod_in, forced to 0 while mute=1.
REQ-013 level  out  16  most recent measured average of demod_in.

Function
REQ-014 Table: 8 x 40-bit registers; a cfg_we write takes effect at the next edge in every state.
REQ-015 FSM states: RETUNE, SETTLE, MEASURE, PLAY.
REQ-016 RETUNE: lasts exactly 1 cycle; loads phase_inc <= table[chan], clears the settle counter and the accumulator, then goes to SETTLE.
REQ-017 If cfg_we targets chan in the RETUNE cycle, phase_inc loads cfg_data (write-through).
REQ-018 SETTLE: counts demod_tick; on the SETTLE_TICKS-th tick goes to MEASURE; samples are discarded.
REQ-019 MEASURE: acc += demod_in on each tick (24-bit, no overflow); after 2^MEAS_LOG2 ticks, level <= acc >> MEAS_LOG2 (low 16 bits), then goes to PLAY (or scan step, REQ-030).
REQ-020 mute=1 in RETUNE, SETTLE and MEASURE; mute=0 only in PLAY; mute changes on the same edge as the state change.
REQ-021 audio_out updates one cycle after each demod_tick; it holds its value otherwise.
REQ-022 PLAY: request priority is sel_req > next_req > prev_req; the winning request updates chan on the same edge as the move to RETUNE.
REQ-023 Wrap: chan 7 + next -> 0; chan 0 + prev -> 7; sel_req to the current chan still retunes.
REQ-024 A cfg_we to address chan in PLAY, with no request, triggers RETUNE of the same chan.
REQ-025 next/prev/sel/scan requests arriving while busy=1 are dropped, not queued.
REQ-026 demod_tick in the RETUNE cycle is ignored (not counted).

Reset
REQ-027 On RSTb low: state=RETUNE, chan=0, mute=1, busy=1, audio_out=0, level=0, counters=0, scan inactive.
REQ-028 On RSTb low: table[0]=40'h7FCB923A2 (936 kHz at 30 MHz), table[1..7]=0, phase_inc=40'h7FCB923A2.
REQ-029 When RSTb is asserted mid-operation, the block abandons any state immediately; after release it performs a full RETUNE/SETTLE/MEASURE of channel 0.

Configuration
REQ-030 With TUNE_SCAN_EN defined: scan_req in PLAY sets scan_active and lap=0, advances chan+1 and enters RETUNE. At each MEASURE end with scan_active: if level >= scan_thresh, the block clears scan_active and enters PLAY; otherwise lap++, chan+1 (wrapping), and RETUNE. When lap reaches 8, the block clears scan_active and enters PLAY on the current channel. next/prev/sel requests are ignored during a scan.
REQ-031 Without TUNE_SCAN_EN: no scan logic is built; scan_req and scan_thresh are ignored; MEASURE always ends in PLAY.

Verification
REQ-032 Reset release, SETTLE_TICKS=32, MEAS_LOG2=8, demod_tick every 4 cycles, demod_in=1000 -> phase_inc=40'h7FCB923A2, mute=1 for 288 ticks, then PLAY, level=1000, mute=0.
REQ-033 In PLAY, chan=7, next_req pulse -> chan=0, phase_inc=table[0] one cycle later, busy=1; prev_req at chan=0 -> chan=7.
REQ-034 Same-cycle sel_req (sel_chan=5) and next_req at chan=2 -> chan=5; a next_req pulse during SETTLE -> no effect.
REQ-035 cfg_we addr=chan during the RETUNE cycle with data 40'h123456789A -> phase_inc=40'h123456789A.
REQ-036 TUNE_SCAN_EN, scan_thresh=500, channel levels {100,100,600,...} starting from chan 0 -> scan stops at chan 2 with mute=0; with all levels 100 -> stops after 8 laps at chan 0.
REQ-037 RSTb pulsed low during MEASURE at chan=4 -> chan=0, mute=1, level=0 immediately.
